// File: rtl/rv32i_pkg.sv
// Shared rv32i encodings: ALU opcodes, result-source and forward-select codes,
// plus the EX control bundle and the forward-select helper.
package rv32i_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } res_src_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic [2:0] alu_control;
    logic [1:0] result_src;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ex_ctrl_t;

  // MEM is the younger writer, so it wins over WB; x0 is never a forward target.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd,
                                         input logic       mem_we,
                                         input logic [4:0] wb_rd,
                                         input logic       wb_we);
    if (rs == 5'd0)                return FWD_REG;
    if (mem_we && mem_rd == rs)    return FWD_MEM;
    if (wb_we && wb_rd == rs)      return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational operand-forward select for the two EX source registers.
module forward_unit
  import rv32i_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] forward_a,
  output logic [1:0] forward_b
);

  assign forward_a = fwd_sel(rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign forward_b = fwd_sel(rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and MEM/WB forwarding.
// ID_EX_FORWARD_EN enables forwarding; without it every RAW on EX/MEM stalls.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_alu_src,
  input  logic [2:0]      id_alu_control,
  input  logic [1:0]      id_result_src,
  input  logic            id_reg_write,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic [4:0]      mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  input  logic            ex_stall,
  input  logic            flush,
  output logic [XLEN-1:0] srcA,
  output logic [XLEN-1:0] srcB,
  output logic [2:0]      ALUControl,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_write_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [1:0]      ex_result_src,
  output logic            ex_reg_write,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b
);

  ex_ctrl_t        ctrl_q, id_ctrl;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q, pc_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic            hazard, load_use;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  assign load_use = ctrl_q.valid && (ctrl_q.result_src == RES_LOAD) && (rd_q != 5'd0) &&
                    id_valid && (rd_q == id_rs1 || rd_q == id_rs2);

`ifdef ID_EX_FORWARD_EN
  forward_unit u_fwd (
    .rs1           (rs1_q),
    .rs2           (rs2_q),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .forward_a     (forward_a),
    .forward_b     (forward_b)
  );

  assign hazard  = load_use;
  assign fwd_rs1 = (forward_a == FWD_MEM) ? mem_alu_result :
                   (forward_a == FWD_WB)  ? wb_result : rd1_q;
  assign fwd_rs2 = (forward_b == FWD_MEM) ? mem_alu_result :
                   (forward_b == FWD_WB)  ? wb_result : rd2_q;
`else
  logic ex_raw, mem_raw, unused_fwd;

  // Without forwarding, any pending writer in EX or MEM blocks decode; WB is
  // covered by the write-before-read register file.
  assign ex_raw    = ctrl_q.valid && ctrl_q.reg_write && (rd_q != 5'd0) &&
                     (rd_q == id_rs1 || rd_q == id_rs2);
  assign mem_raw   = mem_reg_write && (mem_rd != 5'd0) &&
                     (mem_rd == id_rs1 || mem_rd == id_rs2);
  assign hazard    = load_use || (id_valid && (ex_raw || mem_raw));
  assign forward_a = FWD_REG;
  assign forward_b = FWD_REG;
  assign fwd_rs1   = rd1_q;
  assign fwd_rs2   = rd2_q;
  assign unused_fwd = ^{mem_alu_result, wb_result, wb_rd, wb_reg_write, rs1_q, rs2_q};
`endif

  assign id_ready = !ex_stall && !hazard;

  always_comb begin
    id_ctrl = '0;
    if (id_valid) begin
      id_ctrl.valid       = 1'b1;
      id_ctrl.alu_src     = id_alu_src;
      id_ctrl.alu_control = id_alu_control;
      id_ctrl.result_src  = id_result_src;
      id_ctrl.reg_write   = id_reg_write;
      id_ctrl.mem_write   = id_mem_write;
      id_ctrl.branch      = id_branch;
      id_ctrl.jump        = id_jump;
    end
  end

  // Stall outranks flush/hazard: a held register must not be overwritten by a bubble.
  always_ff @(posedge clk) begin
    if (reset || (!ex_stall && (flush || hazard))) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
    end else if (!ex_stall) begin
      ctrl_q <= id_ctrl;
      rd1_q  <= id_rd1;
      rd2_q  <= id_rd2;
      imm_q  <= id_imm;
      pc_q   <= id_pc;
      rs1_q  <= id_rs1;
      rs2_q  <= id_rs2;
      rd_q   <= id_rd;
    end
  end

  assign srcA          = fwd_rs1;
  assign ex_write_data = fwd_rs2;
  assign srcB          = ctrl_q.alu_src ? imm_q : fwd_rs2;
  assign ALUControl    = ctrl_q.alu_control;
  assign ex_valid      = ctrl_q.valid;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;
  assign ex_rd         = rd_q;
  assign ex_result_src = ctrl_q.result_src;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jump       = ctrl_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: forward-mux vector table, hand-written hazard/stall/reset
// sequences, then random traffic against an instruction-level model.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        alu_src;
    logic [2:0]  aluc;
    logic [1:0]  rsrc;
    logic        rw, mw, br, jp;
  } ins_t;

  typedef struct packed {
    logic [4:0]  mrd;
    logic        mwe;
    logic [4:0]  wrd;
    logic        wwe;
    logic [1:0]  fa;
    logic [31:0] a;
    logic [1:0]  fb;
    logic [31:0] b;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, ex_stall, flush;
  ins_t        id, m;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_alu_result, wb_result;

  logic        id_ready, ex_valid, ex_reg_write, ex_mem_write, ex_branch, ex_jump;
  logic [31:0] srcA, srcB, ex_write_data, ex_pc, ex_imm;
  logic [2:0]  ALUControl;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_result_src, forward_a, forward_b;

  int total = 0;
  int bad = 0;
  vec_t vt[6];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id.valid), .id_ready(id_ready),
    .id_rd1(id.rd1), .id_rd2(id.rd2),
    .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
    .id_imm(id.imm), .id_pc(id.pc),
    .id_alu_src(id.alu_src), .id_alu_control(id.aluc), .id_result_src(id.rsrc),
    .id_reg_write(id.rw), .id_mem_write(id.mw), .id_branch(id.br), .id_jump(id.jp),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_alu_result(mem_alu_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_stall(ex_stall), .flush(flush),
    .srcA(srcA), .srcB(srcB), .ALUControl(ALUControl),
    .ex_valid(ex_valid), .ex_write_data(ex_write_data),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_result_src(ex_result_src),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump),
    .forward_a(forward_a), .forward_b(forward_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: which producer supplies a source register right now.
  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (!FWD || rs == 5'd0) return 2'b00;
    if (mem_reg_write && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_val(input logic [4:0] rs, input logic [31:0] r);
    case (m_fwd(rs))
      2'b10:   return mem_alu_result;
      2'b01:   return wb_result;
      default: return r;
    endcase
  endfunction

  function automatic bit m_hazard();
    bit hit_ex, hit_mem;
    if (!id.valid) return 1'b0;
    hit_ex  = m.valid && m.rd != 5'd0 && (m.rd == id.rs1 || m.rd == id.rs2);
    hit_mem = mem_reg_write && mem_rd != 5'd0 && (mem_rd == id.rs1 || mem_rd == id.rs2);
    if (hit_ex && m.rsrc == 2'b01) return 1'b1;
    return !FWD && ((hit_ex && m.rw) || hit_mem);
  endfunction

  task automatic check_all();
    logic [31:0] b;
    b = m_val(m.rs2, m.rd2);
    chk("id_ready", {31'd0, id_ready}, {31'd0, !ex_stall && !m_hazard()});
    chk("srcA", srcA, m_val(m.rs1, m.rd1));
    chk("srcB", srcB, m.alu_src ? m.imm : b);
    chk("ex_write_data", ex_write_data, b);
    chk("ALUControl", {29'd0, ALUControl}, {29'd0, m.aluc});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
    chk("ex_ctrl", {24'd0, ex_result_src, ex_reg_write, ex_mem_write, ex_branch, ex_jump},
        {24'd0, m.rsrc, m.rw, m.mw, m.br, m.jp});
    chk("forward_a", {30'd0, forward_a}, {30'd0, m_fwd(m.rs1)});
    chk("forward_b", {30'd0, forward_b}, {30'd0, m_fwd(m.rs2)});
  endtask

  // Advance the model by the same clock edge the DUT sees.
  task automatic tick();
    bit hz;
    hz = m_hazard();
    if (reset) m = '0;
    else if (!ex_stall) begin
      if (flush || hz) m = '0;
      else begin
        m = id;
        if (!id.valid) begin
          m.alu_src = 1'b0; m.aluc = 3'd0; m.rsrc = 2'd0;
          m.rw = 1'b0; m.mw = 1'b0; m.br = 1'b0; m.jp = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    #1;
    check_all();
    tick();
  endtask

  task automatic clear_fwd_src();
    mem_rd = 5'd0; mem_reg_write = 1'b0; mem_alu_result = 32'd0;
    wb_rd = 5'd0;  wb_reg_write = 1'b0;  wb_result = 32'd0;
  endtask

  function automatic ins_t rnd_ins();
    ins_t r;
    r.valid   = ($urandom_range(0, 3) != 0);
    r.rd1     = $urandom; r.rd2 = $urandom; r.imm = $urandom; r.pc = $urandom;
    r.rs1     = 5'($urandom_range(0, 7));
    r.rs2     = 5'($urandom_range(0, 7));
    r.rd      = 5'($urandom_range(0, 7));
    r.alu_src = 1'($urandom);
    r.aluc    = 3'($urandom);
    r.rsrc    = 2'($urandom_range(0, 2));
    r.rw      = 1'($urandom); r.mw = 1'($urandom);
    r.br      = 1'($urandom); r.jp = 1'($urandom);
    return r;
  endfunction

  initial begin
    m = '0; id = '0; ex_stall = 1'b0; flush = 1'b0; reset = 1'b1;
    clear_fwd_src();
    tick();
    reset = 1'b0;

    // Reset state, and x0 never forwards even with live MEM/WB writers of index 0.
    mem_reg_write = 1'b1; mem_alu_result = 32'h55; wb_reg_write = 1'b1; wb_result = 32'h66;
    #1;
    chk("rst_srcA", srcA, 32'd0);
    chk("rst_srcB", srcB, 32'd0);
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("x0_forward_a", {30'd0, forward_a}, 32'd0);
    check_all();
    clear_fwd_src();
    tick();

    // Basic capture.
    id = '0; id.valid = 1'b1; id.rd1 = 32'd1025; id.rd2 = 32'd1000; id.aluc = 3'b001;
    id.rs1 = 5'd1; id.rs2 = 5'd2; id.rd = 5'd3; id.rw = 1'b1;
    cycle();
    id = '0;
    #1;
    chk("cap_srcA", srcA, 32'd1025);
    chk("cap_srcB", srcB, 32'd1000);
    chk("cap_aluc", {29'd0, ALUControl}, 32'd1);
    chk("cap_valid", {31'd0, ex_valid}, 32'd1);
    tick();

    // Forward-mux vector table on an EX instruction with rs1=5, rs2=6.
    id = '0; id.valid = 1'b1; id.rs1 = 5'd5; id.rs2 = 5'd6; id.rd = 5'd9; id.rw = 1'b1;
    id.rd1 = 32'd1025; id.rd2 = 32'd1000;
    cycle();
    id = '0; ex_stall = 1'b1; mem_alu_result = 32'h100; wb_result = 32'h200;
    vt[0] = '{5'd5, 1'b1, 5'd5, 1'b1, FWD ? 2'd2 : 2'd0, FWD ? 32'h100 : 32'd1025, 2'd0, 32'd1000};
    vt[1] = '{5'd0, 1'b1, 5'd5, 1'b1, FWD ? 2'd1 : 2'd0, FWD ? 32'h200 : 32'd1025, 2'd0, 32'd1000};
    vt[2] = '{5'd5, 1'b0, 5'd5, 1'b1, FWD ? 2'd1 : 2'd0, FWD ? 32'h200 : 32'd1025, 2'd0, 32'd1000};
    vt[3] = '{5'd6, 1'b1, 5'd6, 1'b1, 2'd0, 32'd1025, FWD ? 2'd2 : 2'd0, FWD ? 32'h100 : 32'd1000};
    vt[4] = '{5'd6, 1'b0, 5'd6, 1'b1, 2'd0, 32'd1025, FWD ? 2'd1 : 2'd0, FWD ? 32'h200 : 32'd1000};
    vt[5] = '{5'd0, 1'b0, 5'd0, 1'b1, 2'd0, 32'd1025, 2'd0, 32'd1000};
    for (int i = 0; i < 6; i++) begin
      mem_rd = vt[i].mrd; mem_reg_write = vt[i].mwe; wb_rd = vt[i].wrd; wb_reg_write = vt[i].wwe;
      #1;
      chk($sformatf("vec%0d_fa", i), {30'd0, forward_a}, {30'd0, vt[i].fa});
      chk($sformatf("vec%0d_srcA", i), srcA, vt[i].a);
      chk($sformatf("vec%0d_fb", i), {30'd0, forward_b}, {30'd0, vt[i].fb});
      chk($sformatf("vec%0d_srcB", i), srcB, vt[i].b);
    end
    clear_fwd_src();
    tick();
    ex_stall = 1'b0;

    // Load-use: load to x7 in EX, dependent on rs2=7 in ID.
    id = '0; id.valid = 1'b1; id.rd = 5'd7; id.rsrc = 2'b01; id.rw = 1'b1; id.rs1 = 5'd1; id.rs2 = 5'd2;
    cycle();
    id = '0; id.valid = 1'b1; id.rs1 = 5'd4; id.rs2 = 5'd7; id.rd = 5'd8; id.rw = 1'b1;
    id.rd1 = 32'h44; id.rd2 = 32'hbad;
    #1;
    chk("lu_ready_c0", {31'd0, id_ready}, 32'd0);
    check_all();
    tick();
    mem_rd = 5'd7; mem_reg_write = 1'b1; mem_alu_result = 32'h777;
    #1;
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_ready_c1", {31'd0, id_ready}, {31'd0, FWD});
    check_all();
    tick();
    #1;
    chk("lu_enter_valid", {31'd0, ex_valid}, {31'd0, FWD});
    chk("lu_enter_fb", {30'd0, forward_b}, FWD ? 32'd2 : 32'd0);
    chk("lu_enter_srcB", srcB, FWD ? 32'h777 : 32'd0);
    check_all();
    tick();
    clear_fwd_src();
    wb_rd = 5'd7; wb_reg_write = 1'b1; wb_result = 32'h777;
    #1;
    chk("lu_ready_c3", {31'd0, id_ready}, 32'd1);
    check_all();
    tick();
    id = '0; clear_fwd_src();
    #1;
    chk("lu_final_rd", {27'd0, ex_rd}, 32'd8);
    tick();

    // Stall holds everything for 3 cycles; flush in the middle has no effect.
    id = '0; id.valid = 1'b1; id.rd = 5'd10; id.rw = 1'b1; id.mw = 1'b1; id.br = 1'b1;
    id.pc = 32'h1000; id.imm = 32'h20; id.alu_src = 1'b1; id.aluc = 3'b010;
    id.rs1 = 5'd1; id.rs2 = 5'd2; id.rd1 = 32'h11; id.rd2 = 32'h22;
    cycle();
    id.rd = 5'd11; id.pc = 32'h2000; id.rs1 = 5'd3; id.rs2 = 5'd4;
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flush = (k == 1);
      #1;
      chk($sformatf("stall%0d_rd", k), {27'd0, ex_rd}, 32'd10);
      chk($sformatf("stall%0d_pc", k), ex_pc, 32'h1000);
      chk($sformatf("stall%0d_srcB", k), srcB, 32'h20);
      chk($sformatf("stall%0d_ready", k), {31'd0, id_ready}, 32'd0);
      check_all();
      tick();
    end
    flush = 1'b0;
    #1;
    chk("stall_after_valid", {31'd0, ex_valid}, 32'd1);
    ex_stall = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);

    // Reset while stalled clears the stage.
    cycle();
    ex_stall = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rststall_valid", {31'd0, ex_valid}, 32'd0);
    chk("rststall_srcA", srcA, 32'd0);
    chk("rststall_srcB", srcB, 32'd0);
    chk("rststall_pc", ex_pc, 32'd0);
    chk("rststall_ctrl", {27'd0, ex_rd, ex_reg_write, ex_mem_write, ex_branch} == 0 ? 32'd0 : 32'd1, 32'd0);
    ex_stall = 1'b0;

    // RAW against a MEM-stage writer: stalls only when forwarding is off.
    id = '0; id.valid = 1'b1; id.rs1 = 5'd3; id.rd = 5'd12;
    mem_rd = 5'd3; mem_reg_write = 1'b1; mem_alu_result = 32'h333;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("memraw%0d_ready", k), {31'd0, id_ready}, {31'd0, FWD});
      chk($sformatf("memraw%0d_fa", k), {30'd0, forward_a}, (FWD && k == 1) ? 32'd2 : 32'd0);
      check_all();
      tick();
    end
    clear_fwd_src();
    #1;
    chk("memraw_release", {31'd0, id_ready}, 32'd1);
    chk("memraw_fa_rel", {30'd0, forward_a}, 32'd0);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      id       = rnd_ins();
      mem_rd   = 5'($urandom_range(0, 7)); mem_reg_write = 1'($urandom); mem_alu_result = $urandom;
      wb_rd    = 5'($urandom_range(0, 7)); wb_reg_write  = 1'($urandom); wb_result      = $urandom;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
